// File: rtl/micro_instruction_executor_pkg.sv
// rtl/micro_instruction_executor_pkg.sv - shared types and constants for the OPR micro-instruction executor
package micro_instruction_executor_pkg;

    typedef logic [11:0] word_t;

    localparam logic [2:0] OPR_OPCODE = 3'b111;

    localparam int CLA_BIT = 7;
    localparam int OSR_BIT = 2;
    localparam int HLT_BIT = 1;
    localparam int MQA_BIT = 6;
    localparam int MQL_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_DONE   = 2'd2,
        ST_HALTED = 2'd3
    } exec_state_t;

endpackage

// File: rtl/micro_instruction_executor_if.sv
// rtl/micro_instruction_executor_if.sv - instruction offer and result bus of the OPR executor
interface micro_instruction_executor_if;
    import micro_instruction_executor_pkg::*;

    logic        op_valid;
    logic        op_ready;
    logic [11:0] op_ir;
    word_t       ac_in;
    logic        l_in;
    word_t       sr_in;
    word_t       ac_out;
    logic        l_out;
    word_t       mq_out;
    logic        skip;
    logic        done;

    modport master (
        output op_valid, op_ir, ac_in, l_in, sr_in,
        input  op_ready, ac_out, l_out, mq_out, skip, done
    );

    modport slave (
        input  op_valid, op_ir, ac_in, l_in, sr_in,
        output op_ready, ac_out, l_out, mq_out, skip, done
    );

endinterface

// File: rtl/micro_instruction_decoder.sv
// rtl/micro_instruction_decoder.sv - combinational group 1 AC/L result, group 2 skip and group flags
module micro_instruction_decoder
    import micro_instruction_executor_pkg::*;
(
    input  logic [8:0] ir,
    input  word_t      ac,
    input  logic       l,
    output word_t      g1_ac,
    output logic       g1_l,
    output logic       skip,
    output logic       is_grp1,
    output logic       is_grp2,
    output logic       is_grp3
);

    logic [12:0] v;
    logic        cond;

    always_comb begin
        is_grp1 = ~ir[8];
        is_grp2 = ir[8] & ~ir[0];
        is_grp3 = ir[8] & ir[0];

        // {L,AC} treated as one 13-bit register so IAC carry and rotates cross into L
        v = {l, ac};
        if (ir[CLA_BIT]) v[11:0] = 12'd0;
        if (ir[6])       v[12]   = 1'b0;
        if (ir[5])       v[11:0] = ~v[11:0];
        if (ir[4])       v[12]   = ~v[12];
        if (ir[0])       v       = v + 13'd1;
        if (ir[3]) begin
            v = {v[0], v[12:1]};
            if (ir[1]) v = {v[0], v[12:1]};
        end else if (ir[2]) begin
            v = {v[11:0], v[12]};
            if (ir[1]) v = {v[11:0], v[12]};
        end else if (ir[1]) begin
            v[11:0] = {v[5:0], v[11:6]};
        end
        g1_ac = v[11:0];
        g1_l  = v[12];

        // bit 3 inverts the sense: skip only when every selected condition is false
        cond = (ir[6] & ac[11]) | (ir[5] & (ac == 12'd0)) | (ir[4] & l);
        skip = is_grp2 & (ir[3] ^ cond);
    end

endmodule

// File: rtl/micro_instruction_executor.sv
// rtl/micro_instruction_executor.sv - sequential OPR front end owning MQ, halt state and result registers
module micro_instruction_executor
    import micro_instruction_executor_pkg::*;
#(
    parameter logic [2:0] OPR_OPCODE      = 3'b111,
    parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    micro_instruction_executor_if.slave bus,
    input  logic cont,
    output logic halted,
    output logic illegal
);

    exec_state_t state_q, state_d;
    logic [8:0]  ir_q, ir_d;
    word_t       ac_q, ac_d;
    logic        l_q, l_d;
    word_t       mq_q, mq_d;
    logic        halt_req_q, halt_req_d;
    word_t       ac_out_q, ac_out_d;
    logic        l_out_q, l_out_d;
    logic        skip_q, skip_d;
    logic        illegal_q, illegal_d;

    word_t       g1_ac;
    logic        g1_l;
    logic        dec_skip;
    logic        is_grp1, is_grp2, is_grp3;
    word_t       a1;

    micro_instruction_decoder u_decoder (
        .ir      (ir_q),
        .ac      (ac_q),
        .l       (l_q),
        .g1_ac   (g1_ac),
        .g1_l    (g1_l),
        .skip    (dec_skip),
        .is_grp1 (is_grp1),
        .is_grp2 (is_grp2),
        .is_grp3 (is_grp3)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ac_d       = ac_q;
        l_d        = l_q;
        mq_d       = mq_q;
        halt_req_d = halt_req_q;
        ac_out_d   = ac_out_q;
        l_out_d    = l_out_q;
        skip_d     = skip_q;
        illegal_d  = 1'b0;
        a1         = ir_q[CLA_BIT] ? 12'd0 : ac_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    if (bus.op_ir[11:9] == OPR_OPCODE) begin
                        ir_d    = bus.op_ir[8:0];
                        ac_d    = bus.ac_in;
                        l_d     = bus.l_in;
                        state_d = ST_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                        if (HALT_ON_ILLEGAL) state_d = ST_HALTED;
                    end
                end
            end
            ST_EXEC: begin
                halt_req_d = 1'b0;
                skip_d     = 1'b0;
                l_out_d    = l_q;
                if (is_grp1) begin
                    ac_out_d = g1_ac;
                    l_out_d  = g1_l;
                end else if (is_grp2) begin
                    ac_out_d   = a1 | (ir_q[OSR_BIT] ? bus.sr_in : 12'd0);
                    skip_d     = dec_skip;
                    halt_req_d = ir_q[HLT_BIT];
                end else if (is_grp3) begin
                    // MQA together with MQL exchanges AC and MQ (SWP)
                    if (ir_q[MQL_BIT]) begin
                        ac_out_d = ir_q[MQA_BIT] ? mq_q : 12'd0;
                        mq_d     = a1;
                    end else begin
                        ac_out_d = ir_q[MQA_BIT] ? (a1 | mq_q) : a1;
                    end
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = halt_req_q ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                if (cont) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ir_q       <= 9'd0;
            ac_q       <= 12'd0;
            l_q        <= 1'b0;
            mq_q       <= 12'd0;
            halt_req_q <= 1'b0;
            ac_out_q   <= 12'd0;
            l_out_q    <= 1'b0;
            skip_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ac_q       <= ac_d;
            l_q        <= l_d;
            mq_q       <= mq_d;
            halt_req_q <= halt_req_d;
            ac_out_q   <= ac_out_d;
            l_out_q    <= l_out_d;
            skip_q     <= skip_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.op_ready = (state_q == ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.skip     = (state_q == ST_DONE) & skip_q;
    assign bus.ac_out   = ac_out_q;
    assign bus.l_out    = l_out_q;
    assign bus.mq_out   = mq_q;
    assign halted       = (state_q == ST_HALTED);
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_micro_instruction_executor.sv
// tb/tb_micro_instruction_executor.sv - randomized self-checking bench for the OPR executor
module tb_micro_instruction_executor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cont = 1'b0;
    logic halted;
    logic illegal;

    int checks = 0;
    int errors = 0;
    logic [11:0] m_mq = 12'd0;

    micro_instruction_executor_if bus ();

    micro_instruction_executor #(.OPR_OPCODE(3'b111), .HALT_ON_ILLEGAL(1'b0)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cont    (cont),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // Reference: PDP-8 operate-instruction semantics with plain integer arithmetic
    task automatic model(input logic [11:0] ir, input logic [11:0] ac, input logic l,
                         input logic [11:0] sr, input logic [11:0] mq,
                         output logic [11:0] e_ac, output logic e_l, output logic [11:0] e_mq,
                         output logic e_skip, output logic e_halt);
        int v;
        int n;
        bit cond;
        logic [11:0] a1;
        e_mq = mq; e_skip = 1'b0; e_halt = 1'b0; e_l = l;
        if (ir[8] == 1'b0) begin
            v = l * 4096 + ac;
            if (ir[7]) v = v - (v % 4096);
            if (ir[6]) v = v % 4096;
            if (ir[5]) v = (v / 4096) * 4096 + (4095 - v % 4096);
            if (ir[4]) v = (v % 4096) + (1 - v / 4096) * 4096;
            if (ir[0]) v = (v + 1) % 8192;
            n = ir[1] ? 2 : 1;
            if (ir[3]) begin
                for (int k = 0; k < n; k++) v = (v / 2) + (v % 2) * 4096;
            end else if (ir[2]) begin
                for (int k = 0; k < n; k++) v = (v * 2) % 8192 + v / 4096;
            end else if (ir[1]) begin
                v = (v / 4096) * 4096 + (v % 64) * 64 + (v % 4096) / 64;
            end
            e_ac = v[11:0];
            e_l  = v[12];
        end else if (ir[0] == 1'b0) begin
            cond = (ir[6] && ac >= 12'd2048) || (ir[5] && ac == 12'd0) || (ir[4] && l);
            e_skip = ir[3] ? !cond : cond;
            e_ac = (ir[7] ? 12'd0 : ac) | (ir[2] ? sr : 12'd0);
            e_halt = ir[1];
        end else begin
            a1 = ir[7] ? 12'd0 : ac;
            if (ir[4]) begin
                e_ac = ir[6] ? mq : 12'd0;
                e_mq = a1;
            end else begin
                e_ac = ir[6] ? (a1 | mq) : a1;
            end
        end
    endtask

    task automatic run_op(input logic [11:0] ir, input logic [11:0] ac, input logic l,
                          input logic [11:0] sr, output logic [11:0] o_ac, output logic o_l,
                          output logic [11:0] o_mq, output logic o_skip, output int lat);
        @(negedge clk);
        bus.op_ir = ir; bus.ac_in = ac; bus.l_in = l; bus.sr_in = sr; bus.op_valid = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.done && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        o_ac = bus.ac_out; o_l = bus.l_out; o_mq = bus.mq_out; o_skip = bus.skip;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_mq = 12'd0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.op_ready, bus.done, bus.skip, halted, illegal} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got=%b exp=10000", {bus.op_ready, bus.done, bus.skip, halted, illegal});
        end
        checks++;
        if ({bus.ac_out, bus.l_out, bus.mq_out} !== 25'd0) begin
            errors++; $display("FAIL reset_data ac=%o l=%b mq=%o exp zero", bus.ac_out, bus.l_out, bus.mq_out);
        end
    endtask

    task automatic test_group1();
        logic [11:0] a, m; logic ll, s; int lat;
        run_op(12'o7241, 12'o0000, 1'b0, 12'o0, a, ll, m, s, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL g1_latency got=%0d exp=2", lat); end
        checks++;
        if ({a, ll, s} !== {12'o0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL g1_cla_cma_iac ac=%o l=%b skip=%b exp ac=0000 l=1 skip=0", a, ll, s);
        end
    endtask

    task automatic test_group2();
        logic [11:0] a, m; logic ll, s; int lat;
        run_op(12'o7700, 12'o4000, 1'b0, 12'o0, a, ll, m, s, lat);
        checks++;
        if ({a, s} !== {12'o0000, 1'b1}) begin
            errors++; $display("FAIL g2_sma_cla ac=%o skip=%b exp ac=0000 skip=1", a, s);
        end
        @(negedge clk);
        checks++;
        if (bus.skip !== 1'b0 || bus.ac_out !== 12'o0000) begin
            errors++; $display("FAIL g2_skip_drop skip=%b ac=%o exp skip=0 ac=0000", bus.skip, bus.ac_out);
        end
        run_op(12'o7450, 12'o0000, 1'b0, 12'o0, a, ll, m, s, lat);
        checks++;
        if (s !== 1'b0) begin errors++; $display("FAIL g2_sna skip=%b exp=0", s); end
        run_op(12'o7604, 12'o0017, 1'b0, 12'o5000, a, ll, m, s, lat);
        checks++;
        if ({a, s} !== {12'o5000, 1'b0}) begin
            errors++; $display("FAIL g2_cla_osr ac=%o skip=%b exp ac=5000 skip=0", a, s);
        end
    endtask

    task automatic test_group3();
        logic [11:0] a, m; logic ll, s; int lat;
        do_reset();
        run_op(12'o7421, 12'o1234, 1'b0, 12'o0, a, ll, m, s, lat);
        checks++;
        if ({a, m} !== {12'o0000, 12'o1234}) begin
            errors++; $display("FAIL g3_mql ac=%o mq=%o exp ac=0000 mq=1234", a, m);
        end
        run_op(12'o7521, 12'o0007, 1'b0, 12'o0, a, ll, m, s, lat);
        checks++;
        if ({a, m} !== {12'o1234, 12'o0007}) begin
            errors++; $display("FAIL g3_swp ac=%o mq=%o exp ac=1234 mq=0007", a, m);
        end
        m_mq = 12'o0007;
    endtask

    task automatic test_halt();
        logic [11:0] a, m; logic ll, s; int lat;
        run_op(12'o7402, 12'o0123, 1'b0, 12'o0, a, ll, m, s, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL hlt_done lat=%0d exp=2", lat); end
        @(negedge clk);
        checks++;
        if ({halted, bus.op_ready} !== 2'b10) begin
            errors++; $display("FAIL hlt_state halted=%b ready=%b exp halted=1 ready=0", halted, bus.op_ready);
        end
        bus.op_ir = 12'o7241; bus.op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({halted, bus.done} !== 2'b10) begin
                errors++; $display("FAIL hlt_ignore cyc=%0d halted=%b done=%b exp 1 0", i, halted, bus.done);
            end
        end
        bus.op_valid = 1'b0;
        cont = 1'b1;
        @(posedge clk);
        #1 cont = 1'b0;
        @(negedge clk);
        checks++;
        if ({halted, bus.op_ready} !== 2'b01) begin
            errors++; $display("FAIL hlt_cont halted=%b ready=%b exp halted=0 ready=1", halted, bus.op_ready);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        bus.op_ir = 12'o1234; bus.op_valid = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({illegal, bus.done, bus.op_ready, halted} !== 4'b1010) begin
            errors++; $display("FAIL illegal_pulse ill/done/ready/halt=%b exp 1010", {illegal, bus.done, bus.op_ready, halted});
        end
        @(negedge clk);
        checks++;
        if ({illegal, bus.done} !== 2'b00) begin
            errors++; $display("FAIL illegal_clear ill/done=%b exp 00", {illegal, bus.done});
        end
    endtask

    task automatic test_reset_exec();
        int seen_done = 0;
        @(negedge clk);
        bus.op_ir = 12'o7421; bus.ac_in = 12'o1234; bus.l_in = 1'b0; bus.op_valid = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        m_mq = 12'd0;
        @(negedge clk);
        checks++;
        if ({bus.op_ready, bus.done} !== 2'b10 || bus.mq_out !== 12'o0000) begin
            errors++; $display("FAIL rst_exec ready=%b done=%b mq=%o exp 1 0 0000", bus.op_ready, bus.done, bus.mq_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin errors++; $display("FAIL rst_exec_nodone got=%0d exp=0", seen_done); end
    endtask

    task automatic test_random();
        logic [11:0] ir, ac, sr, a, m, e_ac, e_mq; logic l, ll, s, e_l, e_skip, e_halt; int lat;
        for (int i = 0; i < 300; i++) begin
            ir = {3'b111, 9'($urandom_range(0, 511))};
            if (ir[8] == 1'b0 && ir[3] && ir[2]) ir[2] = 1'b0;
            ac = 12'($urandom); sr = 12'($urandom); l = 1'($urandom);
            if (($urandom & 3) == 0) ac = (($urandom & 1) != 0) ? 12'o0000 : 12'o4000;
            model(ir, ac, l, sr, m_mq, e_ac, e_l, e_mq, e_skip, e_halt);
            run_op(ir, ac, l, sr, a, ll, m, s, lat);
            checks++;
            if (lat !== 2 || {a, ll, m, s} !== {e_ac, e_l, e_mq, e_skip}) begin
                errors++;
                $display("FAIL rand_op ir=%o ac=%o l=%b sr=%o got lat=%0d ac=%o l=%b mq=%o skip=%b exp lat=2 ac=%o l=%b mq=%o skip=%b",
                         ir, ac, l, sr, lat, a, ll, m, s, e_ac, e_l, e_mq, e_skip);
            end
            m_mq = e_mq;
            @(negedge clk);
            checks++;
            if ({bus.skip, bus.done, halted} !== {1'b0, 1'b0, e_halt} || bus.ac_out !== e_ac) begin
                errors++;
                $display("FAIL rand_after ir=%o skip=%b done=%b halted=%b ac=%o exp 0 0 %b %o",
                         ir, bus.skip, bus.done, halted, bus.ac_out, e_halt, e_ac);
            end
            if (halted) begin
                cont = 1'b1;
                @(posedge clk);
                #1 cont = 1'b0;
            end
        end
    endtask

    initial begin
        bus.op_valid = 1'b0; bus.op_ir = 12'd0; bus.ac_in = 12'd0; bus.l_in = 1'b0; bus.sr_in = 12'd0;
        test_reset();
        test_group1();
        test_group2();
        test_group3();
        test_halt();
        test_illegal();
        test_reset_exec();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
